// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control bundle between the multi-cycle sequencer and its datapath/memory
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic             run;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             alu_src;
  logic [2:0]       alu_op;
  logic [2:0]       imm_type;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             busy;
  logic             illegal;
  logic             timeout_err;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  run, opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src, alu_op,
           imm_type, reg_we, wb_sel, busy, illegal, timeout_err, retired
  );

  modport master (
    output run, opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src, alu_op,
           imm_type, reg_we, wb_sel, busy, illegal, timeout_err, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with a shared memory port, watchdog and retire counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR} state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam int         TW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           r_state;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_timeout;

  logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_legal, w_taken;
  logic       w_xfer, w_stall, w_timeout, w_retire;
  logic [2:0] w_alu_arith;
  state_t     w_boundary;

  assign w_is_r   = (bus.opcode == OP_R);
  assign w_is_i   = (bus.opcode == OP_I);
  assign w_is_lw  = (bus.opcode == OP_LW);
  assign w_is_sw  = (bus.opcode == OP_SW);
  assign w_is_br  = (bus.opcode == OP_BR);
  assign w_is_jal = (bus.opcode == OP_JAL);
  assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_jal |
                    (w_is_br & (bus.funct3[2:1] == 2'b00));
  assign w_taken  = w_is_br & (bus.funct3[0] ^ bus.zero);

  always_comb begin
    w_alu_arith = 3'b000;
    case (bus.funct3)
      3'b000:  w_alu_arith = (w_is_r & bus.funct7[5]) ? 3'b001 : 3'b000;
      3'b001:  w_alu_arith = 3'b110;
      3'b010:  w_alu_arith = 3'b101;
      3'b100:  w_alu_arith = 3'b100;
      3'b101:  w_alu_arith = 3'b111;
      3'b110:  w_alu_arith = 3'b011;
      3'b111:  w_alu_arith = 3'b010;
      default: w_alu_arith = 3'b000;
    endcase
  end

  assign w_xfer     = bus.mem_req & bus.mem_ready;
  assign w_stall    = bus.mem_req & ~bus.mem_ready;
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_stall && ((int'(r_wait) + 1) == MEM_TIMEOUT);
  assign w_retire   = ((r_state == S_EXEC) & (w_is_br | w_is_jal)) |
                      ((r_state == S_MEM) & w_xfer & w_is_sw) |
                      (r_state == S_WB);
  assign w_boundary = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_xfer)
        r_wait <= '0;
      else if (w_stall)
        r_wait <= r_wait + 1'b1;

      if (w_retire)
        r_retired <= r_retired + 1'b1;

      // Watchdog wins over any normal transition of the stalled state
      if (w_timeout) begin
        r_timeout <= 1'b1;
        r_wait    <= '0;
        r_state   <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE:   if (bus.run) r_state <= S_FETCH;
          S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
          S_DECODE: begin
            if (w_legal) begin
              r_state <= S_EXEC;
            end else begin
              r_illegal <= 1'b1;
              r_state   <= S_ERR;
            end
          end
          S_EXEC: begin
            if (w_is_br | w_is_jal)
              r_state <= w_boundary;
            else if (w_is_lw | w_is_sw)
              r_state <= S_MEM;
            else
              r_state <= S_WB;
          end
          S_MEM:    if (bus.mem_ready) r_state <= w_is_sw ? w_boundary : S_WB;
          S_WB:     r_state <= w_boundary;
          S_ERR:    r_state <= S_ERR;
          default:  r_state <= S_ERR;
        endcase
      end
    end
  end

  // ALU settings are held through MEM/WB so the address and writeback result stay valid
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.alu_src  = 1'b0;
    bus.alu_op   = 3'b000;
    bus.imm_type = 3'd0;
    bus.reg_we   = 1'b0;
    bus.wb_sel   = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_r | w_is_i) begin
          bus.alu_op  = w_alu_arith;
          bus.alu_src = w_is_i;
        end else if (w_is_lw | w_is_sw) begin
          bus.alu_src  = 1'b1;
          bus.imm_type = w_is_sw ? 3'd1 : 3'd0;
        end else if (w_is_br) begin
          bus.alu_op   = 3'b001;
          bus.imm_type = 3'd2;
          bus.pc_we    = w_taken;
          bus.pc_sel   = w_taken;
        end else if (w_is_jal) begin
          bus.imm_type = 3'd3;
          bus.pc_we    = 1'b1;
          bus.pc_sel   = 1'b1;
          bus.reg_we   = 1'b1;
          bus.wb_sel   = 2'b10;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = w_is_sw;
        bus.alu_src  = 1'b1;
        bus.imm_type = w_is_sw ? 3'd1 : 3'd0;
      end
      S_WB: begin
        bus.reg_we = 1'b1;
        if (w_is_lw) begin
          bus.wb_sel = 2'b01;
        end else begin
          bus.alu_op  = w_alu_arith;
          bus.alu_src = w_is_i;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_ERR);
  assign bus.illegal     = r_illegal;
  assign bus.timeout_err = r_timeout;
  assign bus.retired     = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    int         wf;
    int         wm;
  } ins_t;

  typedef struct {
    int cycles;
    int n_reg;
    int n_pc;
    int n_we;
    int n_mreq;
    int ex_alu;
    int ex_src;
    int ex_imm;
    int ex_taken;
    int wb_sel;
  } res_t;

  typedef struct {
    string name;
    ins_t  in;
    res_t  exp;
    bit    chk_alu;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] strobes();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_sel,
            bus.alu_src, bus.alu_op, bus.imm_type, bus.reg_we, bus.wb_sel};
  endfunction

  // Reference: latency and strobe counts from the instruction class and the memory wait counts
  function automatic res_t model(input ins_t in);
    res_t e;
    bit   r_, i_, lw, sw, br, jal, taken, mem, wb;
    int   alu_of_f3[8] = '{0, 6, 5, 0, 4, 7, 3, 2};
    e     = '{default: 0};
    r_    = (in.opc == 7'b0110011);
    i_    = (in.opc == 7'b0010011);
    lw    = (in.opc == 7'b0000011);
    sw    = (in.opc == 7'b0100011);
    br    = (in.opc == 7'b1100011);
    jal   = (in.opc == 7'b1101111);
    taken = jal || (br && (in.f3 == 3'b000) && in.zero) || (br && (in.f3 == 3'b001) && !in.zero);
    mem   = lw || sw;
    wb    = r_ || i_ || lw;
    e.cycles   = (1 + in.wf) + 1 + 1 + (mem ? 1 + in.wm : 0) + (wb ? 1 : 0);
    e.n_reg    = (wb || jal) ? 1 : 0;
    e.n_pc     = 1 + (taken ? 1 : 0);
    e.n_we     = sw ? in.wm + 1 : 0;
    e.n_mreq   = mem ? in.wm + 1 : 0;
    e.ex_taken = taken ? 1 : 0;
    e.ex_src   = (i_ || mem) ? 1 : 0;
    e.ex_imm   = sw ? 1 : br ? 2 : jal ? 3 : 0;
    e.wb_sel   = jal ? 2 : lw ? 1 : 0;
    if (r_ || i_)
      e.ex_alu = (r_ && in.f3 == 3'b000 && in.f7[5]) ? 1 : alu_of_f3[in.f3];
    else if (br)
      e.ex_alu = 1;
    else
      e.ex_alu = 0;
    return e;
  endfunction

  // Runs one instruction from its first FETCH cycle; returns one cycle past its retiring cycle
  task automatic run_instr(input ins_t in, input int drop_at, output res_t r, output int proto);
    int          k, waited, xfer, target;
    bit          done;
    logic [31:0] r0;
    r      = '{default: 0};
    proto  = 0;
    k      = 0;
    waited = 0;
    xfer   = 0;
    done   = 0;
    r0     = bus.retired;
    while (!done && k < 64) begin
      bus.opcode = in.opc;
      bus.funct3 = in.f3;
      bus.funct7 = in.f7;
      bus.zero   = in.zero;
      if (drop_at >= 0 && k >= drop_at) bus.run = 1'b0;
      target        = (xfer == 0) ? in.wf : in.wm;
      bus.mem_ready = bus.mem_req && (waited >= target);
      #1;
      if (k == in.wf + 2) begin
        r.ex_alu   = int'(bus.alu_op);
        r.ex_src   = int'(bus.alu_src);
        r.ex_imm   = int'(bus.imm_type);
        r.ex_taken = int'(bus.pc_we & bus.pc_sel);
      end
      if (bus.reg_we) begin
        r.n_reg++;
        r.wb_sel = int'(bus.wb_sel);
      end
      if (bus.pc_we) r.n_pc++;
      if (bus.mem_we) r.n_we++;
      if (bus.mem_req && bus.addr_sel) r.n_mreq++;
      if (!bus.busy) proto++;
      if (bus.mem_we && !bus.mem_req) proto++;
      if (bus.ir_we != (bus.mem_req && bus.mem_ready && !bus.addr_sel)) proto++;
      if (bus.ir_we && (!bus.pc_we || bus.pc_sel)) proto++;
      if (bus.mem_req && bus.mem_ready) begin
        xfer++;
        waited = 0;
      end else if (bus.mem_req) begin
        waited++;
      end
      @(posedge clk);
      #1;
      k++;
      if (bus.retired != r0) done = 1;
    end
    r.cycles = done ? k : -1;
  endtask

  task automatic cmp_res(input string n, input res_t g, input res_t e, input bit ca);
    chk({n, ".cycles"}, g.cycles, e.cycles);
    chk({n, ".reg_we"}, g.n_reg, e.n_reg);
    chk({n, ".pc_we"}, g.n_pc, e.n_pc);
    chk({n, ".mem_we"}, g.n_we, e.n_we);
    chk({n, ".mem_req_data"}, g.n_mreq, e.n_mreq);
    chk({n, ".imm_type"}, g.ex_imm, e.ex_imm);
    chk({n, ".taken"}, g.ex_taken, e.ex_taken);
    chk({n, ".wb_sel"}, g.wb_sel, e.wb_sel);
    if (ca) begin
      chk({n, ".alu_op"}, g.ex_alu, e.ex_alu);
      chk({n, ".alu_src"}, g.ex_src, e.ex_src);
    end
  endtask

  initial begin
    res_t        r, e;
    int          p, f3, c, nreq;
    bit          seen;
    ins_t        in;
    logic [31:0] r0;

    bus.run = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;

    vecs.push_back(vec_t'{"addi", ins_t'{7'b0010011, 3'b000, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 0, 1, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"add",  ins_t'{7'b0110011, 3'b000, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 0, 0, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"sub",  ins_t'{7'b0110011, 3'b000, 7'h20, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 1, 0, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"addi_f7", ins_t'{7'b0010011, 3'b000, 7'h20, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 0, 1, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"or",   ins_t'{7'b0110011, 3'b110, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 3, 0, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"andi", ins_t'{7'b0010011, 3'b111, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 2, 1, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"xor",  ins_t'{7'b0110011, 3'b100, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 4, 0, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"slti", ins_t'{7'b0010011, 3'b010, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 5, 1, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"sll",  ins_t'{7'b0110011, 3'b001, 7'h00, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 6, 0, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"srli", ins_t'{7'b0010011, 3'b101, 7'h20, 1'b0, 0, 0}, res_t'{4, 1, 1, 0, 0, 7, 1, 0, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"lw",   ins_t'{7'b0000011, 3'b010, 7'h00, 1'b0, 0, 0}, res_t'{5, 1, 1, 0, 1, 0, 1, 0, 0, 1}, 1'b1});
    vecs.push_back(vec_t'{"sw",   ins_t'{7'b0100011, 3'b010, 7'h00, 1'b0, 0, 0}, res_t'{4, 0, 1, 1, 1, 0, 1, 1, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"beq_z1", ins_t'{7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0}, res_t'{3, 0, 2, 0, 0, 1, 0, 2, 1, 0}, 1'b1});
    vecs.push_back(vec_t'{"bne_z1", ins_t'{7'b1100011, 3'b001, 7'h00, 1'b1, 0, 0}, res_t'{3, 0, 1, 0, 0, 1, 0, 2, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"beq_z0", ins_t'{7'b1100011, 3'b000, 7'h00, 1'b0, 0, 0}, res_t'{3, 0, 1, 0, 0, 1, 0, 2, 0, 0}, 1'b1});
    vecs.push_back(vec_t'{"bne_z0", ins_t'{7'b1100011, 3'b001, 7'h00, 1'b0, 0, 0}, res_t'{3, 0, 2, 0, 0, 1, 0, 2, 1, 0}, 1'b1});
    vecs.push_back(vec_t'{"jal",  ins_t'{7'b1101111, 3'b000, 7'h00, 1'b0, 0, 0}, res_t'{3, 1, 2, 0, 0, 0, 0, 3, 1, 2}, 1'b0});
    vecs.push_back(vec_t'{"lw_wait3", ins_t'{7'b0000011, 3'b010, 7'h00, 1'b0, 0, 3}, res_t'{8, 1, 1, 0, 4, 0, 1, 0, 0, 1}, 1'b1});
    vecs.push_back(vec_t'{"sw_wf2_wm1", ins_t'{7'b0100011, 3'b010, 7'h00, 1'b0, 2, 1}, res_t'{7, 0, 1, 2, 2, 0, 1, 1, 0, 0}, 1'b1});

    #12;
    chk("reset.strobes", strobes(), 0);
    chk("reset.busy", bus.busy, 0);
    chk("reset.flags", {bus.illegal, bus.timeout_err}, 0);
    chk("reset.retired", bus.retired, 0);

    @(negedge clk);
    rst     = 1'b1;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    chk("start.busy", bus.busy, 1);
    chk("start.mem_req", bus.mem_req, 1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].in, -1, r, p);
      n_done++;
      cmp_res(vecs[i].name, r, vecs[i].exp, vecs[i].chk_alu);
      chk({vecs[i].name, ".protocol"}, p, 0);
      chk({vecs[i].name, ".retired"}, bus.retired, n_done);
    end

    // run dropped while a store waits in MEM: store still completes, then idle
    in = ins_t'{7'b0100011, 3'b010, 7'h00, 1'b0, 0, 3};
    run_instr(in, 4, r, p);
    n_done++;
    cmp_res("sw_rundrop", r, res_t'{7, 0, 1, 4, 4, 0, 1, 1, 0, 0}, 1'b1);
    chk("sw_rundrop.retired", bus.retired, n_done);
    for (int k = 0; k < 3; k++) begin
      chk("idle.busy", bus.busy, 0);
      chk("idle.strobes", strobes(), 0);
      @(posedge clk);
      #1;
    end

    bus.run = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 150; i++) begin
      c     = $urandom_range(0, 6);
      in.wf = $urandom_range(0, 4);
      in.wm = $urandom_range(0, 4);
      in.zero = 1'($urandom_range(0, 1));
      in.f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      do f3 = $urandom_range(0, 7); while (f3 == 3);
      in.f3 = 3'(f3);
      case (c)
        0: in.opc = 7'b0110011;
        1: in.opc = 7'b0010011;
        2: begin in.opc = 7'b0000011; in.f3 = 3'b010; end
        3: begin in.opc = 7'b0100011; in.f3 = 3'b010; end
        4: begin in.opc = 7'b1100011; in.f3 = 3'b000; end
        5: begin in.opc = 7'b1100011; in.f3 = 3'b001; end
        default: in.opc = 7'b1101111;
      endcase
      run_instr(in, -1, r, p);
      n_done++;
      e = model(in);
      cmp_res($sformatf("rnd%0d", i), r, e, c != 6);
      chk($sformatf("rnd%0d.protocol", i), p, 0);
    end
    chk("rnd.retired_total", bus.retired, n_done);

    // unsupported opcode: ERR, sticky illegal, no strobes until reset
    r0 = bus.retired;
    bus.opcode    = 7'b1110011;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk("decode.strobes", strobes(), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'b1;
      #1;
      chk("err.illegal", bus.illegal, 1);
      chk("err.busy", bus.busy, 0);
      chk("err.strobes", strobes(), 0);
      chk("err.retired", bus.retired, r0);
      @(posedge clk);
      #1;
    end

    // watchdog on a FETCH that never completes
    #2;
    rst = 1'b0;
    #1;
    chk("rst2.illegal", bus.illegal, 0);
    chk("rst2.retired", bus.retired, 0);
    bus.mem_ready = 1'b0;
    bus.opcode    = 7'b0110011;
    @(negedge clk);
    rst     = 1'b1;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    nreq = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.timeout_err) seen = 1;
      else begin
        if (bus.mem_req) nreq++;
        @(posedge clk);
        #1;
      end
    end
    chk("wdog.seen", seen, 1);
    chk("wdog.req_cycles", nreq, 16);
    chk("wdog.mem_req", bus.mem_req, 0);
    chk("wdog.busy", bus.busy, 0);
    chk("wdog.illegal", bus.illegal, 0);
    @(posedge clk);
    #1;
    chk("wdog.hold", {bus.timeout_err, bus.busy, bus.mem_req}, 3'b100);

    // asynchronous reset in the middle of a FETCH wait
    #2;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("fetch2.mem_req", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.strobes", strobes(), 0);
    chk("arst.busy", bus.busy, 0);
    chk("arst.flags", {bus.illegal, bus.timeout_err}, 0);
    chk("arst.retired", bus.retired, 0);
    @(negedge clk);
    rst = 1'b1;
    #20;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
